if_stage: RTL and testbench

Instruction-fetch stage. Owns the program counter, looks up the instruction at PC in a small direct-mapped instruction cache, and fetches misses from the memory controller over a request/done handshake. It presents `if_pc`/`if_ins` to the IF/ID pipeline register and raises a stall request while an instruction is unavailable. It accepts PC redirects from the execute stage.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 21 ++
 rtl/if_icache.sv | 56 +++++
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam int STALL_W = 3;

    typedef logic [STALL_W-1:0] stall_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INS    = 32'h0000_0013;
    localparam logic [31:0] NOP_PC     = 32'h0000_0000;
    localparam stall_t      STALL_NONE = 3'b000;
    localparam stall_t      STALL_IF   = 3'b001;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:2] addr_hi);
        return {addr_hi, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side memory controller handshake: level request, one-cycle done pulse.
interface if_stage_if;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_done;
    logic [31:0] mem_if_data;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  mem_if_done,
        input  mem_if_data
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output mem_if_done,
        output mem_if_data
    );
endinterface

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Lookup is combinational; fills are written on the clock edge.
// Only valid bits are reset; tag/data contents are don't-care until filled.
module if_icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:2] rd_addr,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic [31:2] waddr,
    input  logic [31:0] wdata
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_addr[2 +: IDX_W];
    assign rd_tag = rd_addr[31 : 2 + IDX_W];
    assign wr_idx = waddr[2 +: IDX_W];
    assign wr_tag = waddr[31 : 2 + IDX_W];

    // Per-line valid bit: cleared by reset, set when that line is filled.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                valid_reg[gi] <= 1'b0;
            end else if (we && (wr_idx == IDX_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    // Tag and data arrays take the fill word; no reset on purpose.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wdata;
        end
    end

    assign hit     = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, cache lookup and miss-fetch FSM.
// A hit is presented in the same cycle; a miss shows a NOP, requests a
// stall and fetches the word through the memory handshake.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int ICACHE_IDX_W = 6
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  stall_t       stall,
    input  logic         jump_en,
    input  logic [31:0]  jump_target,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_ins,
    output logic         stall_req_if,
    if_stage_if.master   mem
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_state_t;

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  fetch_addr_reg;
    logic         mem_req_reg;

    logic         cache_hit;
    logic [31:0]  cache_data;
    logic         fill_we;

    // A fill lands only when the controller completes our own outstanding
    // request; a stray done pulse while idle is ignored.
    assign fill_we = rdy_in && (state_reg == S_WAIT) && mem.mem_if_done;

    if_icache #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_addr (pc_reg[31:2]),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .we      (fill_we),
        .waddr   (fetch_addr_reg[31:2]),
        .wdata   (mem.mem_if_data)
    );

    // PC: redirect beats stall; otherwise advance only when nothing stalls.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_reg <= RESET_PC;
        end else if (rdy_in) begin
            if (jump_en) begin
                pc_reg <= word_align(jump_target[31:2]);
            end else if (stall == STALL_NONE) begin
                pc_reg <= word_align(pc_reg[31:2] + 30'd1);
            end
        end
    end

    // Miss fetch FSM with registered request/address. A redirect while
    // waiting cannot cancel the transaction, so WAIT always ends on done.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg      <= S_IDLE;
            fetch_addr_reg <= RESET_PC;
            mem_req_reg    <= 1'b0;
        end else if (rdy_in) begin
            case (state_reg)
                S_IDLE: begin
                    if (!cache_hit && !jump_en) begin
                        state_reg      <= S_WAIT;
                        fetch_addr_reg <= pc_reg;
                        mem_req_reg    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_if_done) begin
                        state_reg   <= S_IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.if_mem_req  = mem_req_reg;
    assign mem.if_mem_addr = fetch_addr_reg;

    assign if_pc        = pc_reg;
    assign if_ins       = cache_hit ? cache_data : NOP_INS;
    assign stall_req_if = !cache_hit;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a fixed-latency memory responder and a
// minimal stall controller that stalls the pipe whenever IF asks for it.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    stall_t      ext_stall;
    stall_t      stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        stall_req_if;
    logic        hold_off;
    int          cnt;
    int          n_assert;
    int          n_fail;
    int          budget;
    logic        bad_seen;
    logic        saw_req_100;

    if_stage_if bus ();

    if_stage #(
        .ICACHE_IDX_W (6)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        .stall        (stall),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .if_pc        (if_pc),
        .if_ins       (if_ins),
        .stall_req_if (stall_req_if),
        .mem          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stall = ext_stall | (stall_req_if ? STALL_IF : STALL_NONE);

    // Memory image: distinct word per address, 0x00500093 at address 0.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 4);
    endfunction

    // Fixed-latency responder: done pulses LAT cycles after the request rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= 0;
            bus.mem_if_done <= 1'b0;
            bus.mem_if_data <= 32'h0;
        end else begin
            bus.mem_if_done <= 1'b0;
            if (bus.if_mem_req && !bus.mem_if_done && !hold_off) begin
                if (cnt == LAT - 1) begin
                    bus.mem_if_done <= 1'b1;
                    bus.mem_if_data <= word_at(bus.if_mem_addr);
                    cnt             <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic jump_to(input logic [31:0] t);
        jump_en     = 1'b1;
        jump_target = t;
        step();
        jump_en     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; ext_stall = STALL_NONE;
        jump_en = 1'b0; jump_target = 32'h0; hold_off = 1'b0;
        bad_seen = 1'b0; saw_req_100 = 1'b0;
        n_assert = 0; n_fail = 0;
        repeat (2) step();

        check("rst_pc",   if_pc, 32'h0);
        check("rst_ins",  if_ins, 32'h0000_0013);
        check("rst_sreq", 32'(stall_req_if), 32'h1);
        check("rst_req",  32'(bus.if_mem_req), 32'h0);
        check("rst_addr", bus.if_mem_addr, 32'h0);

        // Reset release: request rises one cycle later, fill after latency.
        rst_n = 1'b1;
        step();
        check("rel_req",  32'(bus.if_mem_req), 32'h1);
        check("rel_addr", bus.if_mem_addr, 32'h0);
        repeat (3) step();
        check("wait_ins", if_ins, 32'h0000_0013);
        step();
        check("wait_req", 32'(bus.if_mem_req), 32'h1);
        step();
        check("fill_ins",  if_ins, 32'h0050_0093);
        check("fill_sreq", 32'(stall_req_if), 32'h0);
        check("fill_req",  32'(bus.if_mem_req), 32'h0);
        step();
        check("adv_pc", if_pc, 32'h4);

        // Let the fetch loop fill 0x0..0x1C.
        budget = 300;
        while (if_pc != 32'h20 && budget > 0) begin
            step();
            budget--;
        end
        check("fill8_timeout", 32'(budget > 0), 32'h1);

        // Straight-line hits.
        jump_to(32'h0);
        for (int i = 0; i < 8; i++) begin
            check("hit_pc",   if_pc, 32'(4 * i));
            check("hit_ins",  if_ins, word_at(32'(4 * i)));
            check("hit_sreq", 32'(stall_req_if), 32'h0);
            check("hit_req",  32'(bus.if_mem_req), 32'h0);
            step();
        end

        // Redirect during WAIT.
        jump_to(32'h40);
        check("m40_sreq", 32'(stall_req_if), 32'h1);
        step();
        check("m40_req",  32'(bus.if_mem_req), 32'h1);
        check("m40_addr", bus.if_mem_addr, 32'h40);
        jump_to(32'h100);
        check("rd_pc",   if_pc, 32'h100);
        check("rd_addr", bus.if_mem_addr, 32'h40);
        budget = 100;
        while (stall_req_if && budget > 0) begin
            if (if_pc == 32'h40 && !stall_req_if) bad_seen = 1'b1;
            if (bus.if_mem_req && bus.if_mem_addr == 32'h100) saw_req_100 = 1'b1;
            step();
            budget--;
        end
        check("rd_timeout", 32'(budget > 0), 32'h1);
        check("rd_hit_pc",  if_pc, 32'h100);
        check("rd_hit_ins", if_ins, word_at(32'h100));
        check("rd_req100",  32'(saw_req_100), 32'h1);
        check("rd_no40",    32'(bad_seen), 32'h0);
        jump_to(32'h40);
        check("l40_sreq", 32'(stall_req_if), 32'h0);
        check("l40_ins",  if_ins, word_at(32'h40));

        // Conflict eviction: 0x000 shares index with 0x100.
        jump_to(32'h0);
        check("ev_pc",   if_pc, 32'h0);
        check("ev_sreq", 32'(stall_req_if), 32'h1);
        budget = 100;
        while (stall_req_if && budget > 0) begin
            step();
            budget--;
        end
        check("ev_timeout", 32'(budget > 0), 32'h1);
        check("ev_ins", if_ins, 32'h0050_0093);

        // External stall holds the PC on a hit.
        ext_stall = 3'b110;
        for (int i = 0; i < 3; i++) begin
            step();
            check("xs_pc",  if_pc, 32'h0);
            check("xs_ins", if_ins, 32'h0050_0093);
        end
        ext_stall = STALL_NONE;
        step();
        check("xs_pc4",   if_pc, 32'h4);
        check("xs_sreq",  32'(stall_req_if), 32'h0);
        check("xs_ins4",  if_ins, word_at(32'h4));

        // Freeze mid-WAIT, then asynchronous reset.
        hold_off = 1'b1;
        jump_to(32'h200);
        step();
        check("fz_req0",  32'(bus.if_mem_req), 32'h1);
        check("fz_addr0", bus.if_mem_addr, 32'h200);
        rdy = 1'b0;
        jump_en = 1'b1;
        jump_target = 32'h300;
        repeat (3) step();
        check("fz_pc",   if_pc, 32'h200);
        check("fz_req",  32'(bus.if_mem_req), 32'h1);
        check("fz_addr", bus.if_mem_addr, 32'h200);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",  32'(bus.if_mem_req), 32'h0);
        check("ar_pc",   if_pc, 32'h0);
        check("ar_sreq", 32'(stall_req_if), 32'h1);
        check("ar_addr", bus.if_mem_addr, 32'h0);
        jump_en = 1'b0;
        rdy = 1'b1;
        hold_off = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rr_req",  32'(bus.if_mem_req), 32'h1);
        check("rr_addr", bus.if_mem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
